// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for one shared combinational ALU, with a
// one-entry response buffer tagged by requester id.
module alu_arbiter #(
  parameter int W   = 32,
  parameter int WOP = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [WOP-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [WOP-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic [WOP-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_r,
  input  logic           alu_overflow,
  input  logic           alu_zero,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_r,
  output logic           rsp_overflow,
  output logic           rsp_zero
);

  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_r_q, rsp_r_d;
  logic         rsp_ovf_q, rsp_ovf_d;
  logic         rsp_zero_q, rsp_zero_d;
  logic         prio_q, prio_d;

  logic can_issue, fire0, fire1, fire;

  // The buffer slot frees up in the same cycle it drains, so issue can overlap.
  assign can_issue  = !rst && (!rsp_valid_q || rsp_ready);
  assign req0_ready = can_issue && (!prio_q || !req1_valid);
  assign req1_ready = can_issue && ( prio_q || !req0_valid);

  // At most one of these can be high: with both valid only the prio port is ready.
  assign fire0 = req0_valid && req0_ready;
  assign fire1 = req1_valid && req1_ready;
  assign fire  = fire0 || fire1;

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (fire0) begin
      alu_op = req0_op;
      alu_a  = req0_a;
      alu_b  = req0_b;
    end else if (fire1) begin
      alu_op = req1_op;
      alu_a  = req1_a;
      alu_b  = req1_b;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_r_d     = rsp_r_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_zero_d  = rsp_zero_q;
    prio_d      = prio_q;
    if (fire) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = fire1;
      rsp_r_d     = alu_r;
      rsp_ovf_d   = alu_overflow;
      rsp_zero_d  = alu_zero;
      prio_d      = !fire1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_r_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_r_q     <= rsp_r_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_zero_q  <= rsp_zero_d;
      prio_q      <= prio_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_r        = rsp_r_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_zero     = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a small behavioural ALU answers the DUT's
// ALU drive so responses can be compared with hand-computed results.
module tb_alu_arbiter;
  localparam int W   = 32;
  localparam int WOP = 6;

  localparam logic [WOP-1:0] OP_ADD = 6'd1;
  localparam logic [WOP-1:0] OP_SUB = 6'd2;
  localparam logic [WOP-1:0] OP_SLT = 6'd3;
  localparam logic [WOP-1:0] OP_XOR = 6'd5;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready;
  logic [WOP-1:0] req0_op;
  logic [W-1:0]   req0_a, req0_b;
  logic           req1_valid, req1_ready;
  logic [WOP-1:0] req1_op;
  logic [W-1:0]   req1_a, req1_b;
  logic [WOP-1:0] alu_op;
  logic [W-1:0]   alu_a, alu_b, alu_r;
  logic           alu_overflow, alu_zero;
  logic           rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]   rsp_r;
  logic           rsp_overflow, rsp_zero;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.W(W), .WOP(WOP)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_r(alu_r), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: signed overflow for ADD/SUB only.
  always_comb begin
    alu_r        = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_r        = alu_a + alu_b;
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_r[W-1] != alu_a[W-1]);
      end
      OP_SUB: begin
        alu_r        = alu_a - alu_b;
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_r[W-1] != alu_a[W-1]);
      end
      OP_SLT:  alu_r = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      OP_XOR:  alu_r = alu_a ^ alu_b;
      default: alu_r = '0;
    endcase
    alu_zero = (alu_r == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [WOP-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [WOP-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b1;
    set0(1'b1, OP_ADD, 32'd1, 32'd1);
    set1(1'b1, OP_ADD, 32'd1, 32'd1);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    tick();
    tick();
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    rst = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_overflow, rsp_zero} !== 4'b0000 || rsp_r !== 32'd0) begin
      errors++; $display("FAIL reset_state: got v%b id%b ov%b z%b r%h want all zero",
                         rsp_valid, rsp_id, rsp_overflow, rsp_zero, rsp_r);
    end
    checks++;
    if (alu_op !== '0 || alu_a !== '0 || alu_b !== '0) begin
      errors++; $display("FAIL idle_alu: got op%h a%h b%h want 0", alu_op, alu_a, alu_b);
    end
  endtask

  task automatic test_single_add();
    set0(1'b1, OP_ADD, 32'd5, 32'd3);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== OP_ADD) begin
      errors++; $display("FAIL add_issue: got rdy%b a%h b%h op%h want 1/5/3/%h",
                         req0_ready, alu_a, alu_b, alu_op, OP_ADD);
    end
    tick();
    set0(1'b0, '0, '0, '0);
    checks++;
    if ({rsp_valid, rsp_id, rsp_overflow, rsp_zero} !== 4'b1000 || rsp_r !== 32'd8) begin
      errors++; $display("FAIL add_rsp: got v%b id%b ov%b z%b r%0d want 1 0 0 0 8",
                         rsp_valid, rsp_id, rsp_overflow, rsp_zero, rsp_r);
    end
  endtask

  // Port 1 after a port 0 grant: prio is 1, so this also flips prio back to 0.
  task automatic test_xor_zero();
    set1(1'b1, OP_XOR, 32'hA5A5A5A5, 32'hA5A5A5A5);
    tick();
    set1(1'b0, '0, '0, '0);
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero} !== 3'b111 || rsp_r !== 32'd0) begin
      errors++; $display("FAIL xor_rsp: got v%b id%b z%b r%h want 1 1 1 0",
                         rsp_valid, rsp_id, rsp_zero, rsp_r);
    end
  endtask

  task automatic test_alternate();
    set0(1'b1, OP_ADD, 32'd1, 32'd1);
    set1(1'b1, OP_SUB, 32'd7, 32'd2);
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL alt_ready[%0d]: got %b", k, {req0_ready, req1_ready});
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== logic'(k % 2) || rsp_r !== ((k % 2 == 0) ? 32'd2 : 32'd5)) begin
        errors++; $display("FAIL alt_rsp[%0d]: got v%b id%b r%0d", k, rsp_valid, rsp_id, rsp_r);
      end
    end
  endtask

  // Buffer holds id1/r5 from the alternation run; prio is 0.
  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set0(1'b1, OP_ADD, 32'd10, 32'd20);
    set1(1'b1, OP_SUB, 32'd9, 32'd4);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00 || alu_op !== '0 || alu_a !== '0 || alu_b !== '0) begin
        errors++; $display("FAIL bp_stall[%0d]: got rdy%b op%h a%h b%h want 00 and zero alu",
                           k, {req0_ready, req1_ready}, alu_op, alu_a, alu_b);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_r !== 32'd5) begin
        errors++; $display("FAIL bp_hold[%0d]: got v%b id%b r%0d want 1 1 5", k, rsp_valid, rsp_id, rsp_r);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10 || alu_a !== 32'd10) begin
      errors++; $display("FAIL bp_release: got rdy%b a%0d want 10 and a=10", {req0_ready, req1_ready}, alu_a);
    end
    tick();
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_r !== 32'd30) begin
      errors++; $display("FAIL bp_new_rsp: got v%b id%b r%0d want 1 0 30", rsp_valid, rsp_id, rsp_r);
    end
  endtask

  task automatic test_back_to_back_port1();
    logic [WOP-1:0] ops [3];
    logic [W-1:0]   as [3];
    logic [W-1:0]   bs [3];
    logic [W-1:0]   rs [3];
    logic           ovs [3];
    ops = '{OP_SUB, OP_ADD, OP_SLT};
    as  = '{32'd10, 32'h7FFFFFFF, 32'hFFFFFFFE};
    bs  = '{32'd3,  32'd1,        32'd5};
    rs  = '{32'd7,  32'h80000000, 32'd1};
    ovs = '{1'b0,   1'b1,         1'b0};
    for (int k = 0; k < 3; k++) begin
      set1(1'b1, ops[k], as[k], bs[k]);
      #1;
      checks++;
      if (req1_ready !== 1'b1) begin
        errors++; $display("FAIL p1_ready[%0d]: got %b want 1", k, req1_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_r !== rs[k] || rsp_overflow !== ovs[k]) begin
        errors++; $display("FAIL p1_rsp[%0d]: got v%b id%b r%h ov%b want 1 1 %h %b",
                           k, rsp_valid, rsp_id, rsp_r, rsp_overflow, rs[k], ovs[k]);
      end
    end
    // Idle cycle drains the buffer but keeps data and prio.
    set1(1'b0, '0, '0, '0);
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_r !== 32'd1) begin
      errors++; $display("FAIL idle_drain: got v%b r%h want 0 1", rsp_valid, rsp_r);
    end
    set0(1'b1, OP_ADD, 32'd4, 32'd4);
    set1(1'b1, OP_ADD, 32'd6, 32'd6);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL p1_then_both: got %b want 10", {req0_ready, req1_ready});
    end
    tick();
    checks++;
    if (rsp_id !== 1'b0 || rsp_r !== 32'd8) begin
      errors++; $display("FAIL p1_then_both_rsp: got id%b r%0d want 0 8", rsp_id, rsp_r);
    end
  endtask

  // Buffer holds id0/r8 and prio is 1 on entry.
  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_ready: got %b want 00", {req0_ready, req1_ready});
    end
    tick();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_r !== 32'd0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: got v%b r%h id%b want 0 0 0", rsp_valid, rsp_r, rsp_id);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_mid_grant: got %b want 10", {req0_ready, req1_ready});
    end
    tick();
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_r !== 32'd8) begin
      errors++; $display("FAIL rst_mid_rsp: got v%b id%b r%0d want 1 0 8", rsp_valid, rsp_id, rsp_r);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_add();
    test_xor_zero();
    test_alternate();
    test_backpressure();
    test_back_to_back_port1();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
